// File: rtl/add_pkg.sv
// Shared encodings for the digit-serial adder/subtractor: FSM states and mode values.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry slice adder; also exposes the carry into its top bit for overflow detection.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic             cin,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             ctop
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[DIGIT];
  assign ctop = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of the digit slice adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: processes DIGIT bits per clock, LSB slice first.
module serial_add_sub
  import add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             M,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_add_sub: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, s_q;
  logic               carry_q, cout_q, v_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [DIGIT-1:0]   a_sl, b_sl, sum_sl;
  logic               c_out, c_top;

  assign a_sl = a_q[cnt_q*DIGIT +: DIGIT];
  assign b_sl = b_q[cnt_q*DIGIT +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .cin  (carry_q),
    .a    (a_sl),
    .b    (b_sl),
    .sum  (sum_sl),
    .cout (c_out),
    .ctop (c_top)
  );

  // Subtraction is A + ~B + 1: B is inverted at capture and the mode seeds the carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= (M == MODE_SUB) ? ~B : B;
            carry_q <= (M == MODE_SUB);
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[cnt_q*DIGIT +: DIGIT] <= sum_sl;
          carry_q <= c_out;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q  <= c_out;
            v_q     <= c_top ^ c_out;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: default 8/2 configuration plus a 4/1 back-to-back instance.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, m;
  logic [7:0] a, b;
  logic       busy, done, cout, v;
  logic [7:0] s;

  logic       start2, m2;
  logic [3:0] a2, b2;
  logic       busy2, done2, cout2, v2;
  logic [3:0] s2;

  int n_vec = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(m), .A(a), .B(b),
    .busy(busy), .done(done), .S(s), .Cout(cout), .V(v)
  );

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .M(m2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .S(s2), .Cout(cout2), .V(v2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 8-bit operation with cycle-exact busy/done checks.
  task automatic run_op(input string tag, input logic mm, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] es, input logic ec, input logic ev);
    start = 1'b1; m = mm; a = aa; b = bb;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00; m = 1'b0;
    check({tag, ".busy0"}, busy, 1);
    check({tag, ".done0"}, done, 0);
    for (int i = 0; i < 3; i++) tick();
    check({tag, ".done_early"}, done, 0);
    tick();
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".S"}, s, es);
    check({tag, ".Cout"}, cout, ec);
    check({tag, ".V"}, v, ev);
    tick();
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".S_hold"}, s, es);
  endtask

  initial begin
    int ndone, last, lastS;
    rst_n = 1'b0; start = 1'b1; m = 1'b0; a = 8'h7F; b = 8'h01;
    start2 = 1'b0; m2 = 1'b0; a2 = 4'h0; b2 = 4'h0;
    tick(); tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.S", s, 0);
    check("rst.Cout", cout, 0);
    check("rst.V", v, 0);
    start = 1'b0; rst_n = 1'b1;
    tick();
    check("rst.start_ignored", busy, 0);

    run_op("add7F01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("addFF01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("sub0507", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run_op("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start re-pulsed mid-operation must not disturb the running add.
    start = 1'b1; m = 1'b0; a = 8'h7F; b = 8'h01;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; m = 1'b1; a = 8'h00; b = 8'h55;
    tick();
    start = 1'b0;
    ndone = 0; lastS = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) begin ndone++; lastS = s; end
    end
    check("ign.ndone", ndone, 1);
    check("ign.S", lastS, 8'h80);

    // Reset in the second RUN cycle aborts the operation.
    start = 1'b1; m = 1'b0; a = 8'h12; b = 8'h34;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.S", s, 0);
    check("abort.Cout", cout, 0);
    check("abort.V", v, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort.nodone", ndone, 0);

    // 4-bit, 1 bit per clock, start held: one result every 5 cycles.
    start2 = 1'b1; m2 = 1'b0; a2 = 4'h9; b2 = 4'h8;
    ndone = 0; last = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done2) begin
        ndone++;
        check("b2b.S", s2, 4'h1);
        check("b2b.Cout", cout2, 1);
        check("b2b.V", v2, 1);
        if (last >= 0) check("b2b.period", i - last, 5);
        else check("b2b.first", i, 5);
        last = i;
      end
    end
    check("b2b.ndone", ndone, 4);
    start2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
